// File: rtl/window_threshold_detector.sv
// window_threshold_detector
// Sliding-window threshold vote over a serial bit stream: asserts out when at
// least K of the last W accepted samples were 1, once W samples are held.
// The ones count is maintained incrementally. Every output comes straight
// from a register.
module window_threshold_detector #(
  parameter int W = 3,
  parameter int K = 2,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_val,
  input  logic          in_bit,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          out,
  output logic          hit
);

  // Illegal window/threshold combinations stop elaboration.
  if (W < 2 || W > 64 || K < 1 || K > W) begin : g_bad_params
    $error("window_threshold_detector: W must be 2..64 and K must be 1..W");
  end

  localparam logic [CW-1:0] W_C = CW'(W);
  localparam logic [CW-1:0] K_C = CW'(K);

  logic [W-1:0]  window_q, window_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          full_q, full_d;
  logic          out_q, out_d;
  logic          hit_q, hit_d;

  // The oldest sample leaves the count only once the window is full.
  // Before that point window_q[W-1] is still 0, but the gating keeps the
  // intent explicit.
  logic          evict_s;
  assign evict_s = full_q & window_q[W-1];

  // Next-state selection: flush on clear, slide on accept, hold otherwise.
  always_comb begin
    window_d = window_q;
    count_d  = count_q;
    fill_d   = fill_q;
    full_d   = full_q;
    out_d    = out_q;
    hit_d    = 1'b0;
    if (clear) begin
      // A sample presented together with clear is dropped.
      window_d = {W{1'b0}};
      count_d  = {CW{1'b0}};
      fill_d   = {CW{1'b0}};
      full_d   = 1'b0;
      out_d    = 1'b0;
      hit_d    = 1'b0;
    end else if (in_val) begin
      window_d = {window_q[W-2:0], in_bit};
      count_d  = count_q + {{(CW-1){1'b0}}, in_bit} - {{(CW-1){1'b0}}, evict_s};
      if (fill_q == W_C) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + {{(CW-1){1'b0}}, 1'b1};
      end
      full_d = (fill_d == W_C);
      out_d  = full_d && (count_d >= K_C);
      hit_d  = out_d && !out_q;
    end else begin
      // Idle cycle: the window is sample-indexed, so nothing ages.
      hit_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      window_q <= {W{1'b0}};
      count_q  <= {CW{1'b0}};
      fill_q   <= {CW{1'b0}};
      full_q   <= 1'b0;
      out_q    <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      window_q <= window_d;
      count_q  <= count_d;
      fill_q   <= fill_d;
      full_q   <= full_d;
      out_q    <= out_d;
      hit_q    <= hit_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign out   = out_q;
  assign hit   = hit_q;

endmodule

// File: tb/tb_window_threshold_detector.sv
// Bench for window_threshold_detector. Three configurations (W3/K2, W8/K8,
// W2/K1) share one stimulus stream. A sample-history model predicts every
// output; directed literal checks pin the model to hand-worked values.
module tb_window_threshold_detector;

  logic clk;
  logic rst;
  logic in_val;
  logic in_bit;
  logic clear;

  logic [1:0] c3;
  logic       f3, o3, h3;
  logic [3:0] c8;
  logic       f8, o8, h8;
  logic [1:0] c2;
  logic       f2, o2, h2;

  window_threshold_detector #(.W(3), .K(2)) u3 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .clear(clear),
    .count(c3), .full(f3), .out(o3), .hit(h3)
  );

  window_threshold_detector #(.W(8), .K(8)) u8 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .clear(clear),
    .count(c8), .full(f8), .out(o8), .hit(h8)
  );

  window_threshold_detector #(.W(2), .K(1)) u2 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .clear(clear),
    .count(c2), .full(f2), .out(o2), .hit(h2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, idx, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int wof(input int i);
    case (i)
      0: return 3;
      1: return 8;
      default: return 2;
    endcase
  endfunction

  function automatic int kof(input int i);
    case (i)
      0: return 2;
      1: return 8;
      default: return 1;
    endcase
  endfunction

  bit hist[$];          // accepted samples since last reset/clear, oldest first
  bit started = 1'b0;
  int exp_cnt[3];
  bit exp_full[3];
  bit exp_out[3];
  bit exp_hit[3];

  always @(posedge clk) begin
    if (!rst || clear) begin
      if (!rst) started = 1'b1;
      hist.delete();
      for (int i = 0; i < 3; i++) begin
        exp_cnt[i]  = 0;
        exp_full[i] = 1'b0;
        exp_out[i]  = 1'b0;
        exp_hit[i]  = 1'b0;
      end
    end else if (in_val) begin
      hist.push_back(in_bit);
      if (hist.size() > 64) void'(hist.pop_front());
      for (int i = 0; i < 3; i++) begin
        int n;
        bit nout;
        n = 0;
        for (int j = 0; j < wof(i) && j < hist.size(); j++)
          n += int'(hist[hist.size() - 1 - j]);
        exp_cnt[i]  = n;
        exp_full[i] = (hist.size() >= wof(i));
        nout        = exp_full[i] && (n >= kof(i));
        exp_hit[i]  = nout && !exp_out[i];
        exp_out[i]  = nout;
      end
    end else begin
      for (int i = 0; i < 3; i++) exp_hit[i] = 1'b0;
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (started) begin
      int dc[3];
      bit df[3], dout[3], dh[3];
      dc[0] = int'(c3); df[0] = f3; dout[0] = o3; dh[0] = h3;
      dc[1] = int'(c8); df[1] = f8; dout[1] = o8; dh[1] = h8;
      dc[2] = int'(c2); df[2] = f2; dout[2] = o2; dh[2] = h2;
      for (int i = 0; i < 3; i++) begin
        chk("count", i, dc[i], exp_cnt[i]);
        chk("full", i, int'(df[i]), int'(exp_full[i]));
        chk("out", i, int'(dout[i]), int'(exp_out[i]));
        chk("hit", i, int'(dh[i]), int'(exp_hit[i]));
      end
      chk("popcount", 0, int'(c3), $countones(u3.window_q));
      chk("popcount", 1, int'(c8), $countones(u8.window_q));
      chk("popcount", 2, int'(c2), $countones(u2.window_q));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit r, input bit cl, input bit v, input bit b);
    @(negedge clk);
    rst = r; clear = cl; in_val = v; in_bit = b;
    @(posedge clk);
    #1;
    rst = 1'b1; clear = 1'b0; in_val = 1'b0; in_bit = 1'b0;
  endtask

  task automatic smp(input bit b);
    cyc(1'b1, 1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit exp_o[6];
    bit exp_h[6];
    bit seq[6];
    rst = 1'b0; clear = 1'b0; in_val = 1'b0; in_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 0, int'(c3), 0);
    chk("rst_out", 0, int'(o3), 0);

    // reset then 1,0,1 on W3/K2
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    smp(1'b1); chk("t1_count", 0, int'(c3), 1);
    smp(1'b0); chk("t1_count", 0, int'(c3), 1);
               chk("t1_full", 0, int'(f3), 0);
    smp(1'b1); chk("t1_count", 0, int'(c3), 2);
               chk("t1_full", 0, int'(f3), 1);
               chk("t1_out", 0, int'(o3), 1);
               chk("t1_hit", 0, int'(h3), 1);
    idle(1);   chk("t1_hit_fall", 0, int'(h3), 0);
               chk("t1_out_hold", 0, int'(o3), 1);

    // slide 1,1,0,0,1,1
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    seq   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_o = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_h = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      smp(seq[i]);
      chk("t2_out", i, int'(o3), int'(exp_o[i]));
      chk("t2_hit", i, int'(h3), int'(exp_h[i]));
    end
    chk("t2_count", 0, int'(c3), 2);

    // gaps do not age the window
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    smp(1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("t3_gap_count", i, int'(c3), 1);
      chk("t3_gap_full", i, int'(f3), 0);
      chk("t3_gap_out", i, int'(o3), 0);
    end
    smp(1'b1);
    smp(1'b0); chk("t3_out", 0, int'(o3), 1);

    // clear with a sample present: clear wins, sample dropped
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_clr_count", 0, int'(c3), 0);
    chk("t4_clr_full", 0, int'(f3), 0);
    chk("t4_clr_out", 0, int'(o3), 0);
    chk("t4_clr_hit", 0, int'(h3), 0);
    smp(1'b1); smp(1'b1);
    chk("t4_dropped_count", 0, int'(c3), 2);
    chk("t4_dropped_full", 0, int'(f3), 0);
    smp(1'b1); chk("t4_out", 0, int'(o3), 1);
    // reset pulse mid-stream with a sample present
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4_rst_count", 0, int'(c3), 0);
    chk("t4_rst_out", 0, int'(o3), 0);
    chk("t4_rst_hit", 0, int'(h3), 0);
    smp(1'b1); smp(1'b1); smp(1'b1);
    chk("t4_refill_hit", 0, int'(h3), 1);
    // reset together with clear
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("t4_rc_count", 0, int'(c3), 0);
    chk("t4_rc_full", 0, int'(f3), 0);

    // W8/K8
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) smp(1'b1);
    chk("t5_out", 1, int'(o8), 1);
    chk("t5_hit", 1, int'(h8), 1);
    smp(1'b0);
    chk("t5_out", 1, int'(o8), 0);
    chk("t5_count", 1, int'(c8), 7);
    smp(1'b1);
    chk("t5_count", 1, int'(c8), 7);
    chk("t5_out", 1, int'(o8), 0);

    // W2/K1 boundary
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    smp(1'b1);
    chk("t6_full", 2, int'(f2), 0);
    chk("t6_out", 2, int'(o2), 0);
    smp(1'b0); chk("t6_out", 2, int'(o2), 1);
    smp(1'b0);
    chk("t6_out", 2, int'(o2), 0);
    chk("t6_count", 2, int'(c2), 0);

    // random traffic with occasional clear and reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_val = ($urandom_range(0, 3) != 0);
      in_bit = $urandom_range(0, 1) != 0;
      clear  = ($urandom_range(0, 63) == 0);
      rst    = ($urandom_range(0, 255) != 0);
    end
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; in_val = 1'b0; in_bit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
